// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the data-memory access path.
//   - default address/data widths and byte/half lane widths
//   - RISC-V load/store funct3 codes
//   - FSM state encoding of mem_access_unit
//   - access_size(): maps funct3 to byte/half/word; unlisted codes map to word
package mem_pkg;

   localparam int ADDR_WIDTH_DEF = 32;
   localparam int DATA_WIDTH_DEF = 32;
   localparam int BYTE_WIDTH     = 8;
   localparam int HALF_WIDTH     = 16;

   localparam logic [2:0] F3_B  = 3'b000;   // LB / SB
   localparam logic [2:0] F3_H  = 3'b001;   // LH / SH
   localparam logic [2:0] F3_W  = 3'b010;   // LW / SW
   localparam logic [2:0] F3_BU = 3'b100;   // LBU
   localparam logic [2:0] F3_HU = 3'b101;   // LHU

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_MERGE = 2'd2,
      ST_WRITE = 2'd3
   } mem_state_t;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2
   } access_size_t;

   // Stores only have SB/SH/SW, so the unsigned load codes fall to word there.
   function automatic access_size_t access_size(input logic [2:0] funct3,
                                                input logic       is_store);
      access_size_t sz;
      sz = SZ_WORD;
      if (is_store) begin
         case (funct3)
            F3_B:    sz = SZ_BYTE;
            F3_H:    sz = SZ_HALF;
            default: sz = SZ_WORD;
         endcase
      end else begin
         case (funct3)
            F3_B, F3_BU: sz = SZ_BYTE;
            F3_H, F3_HU: sz = SZ_HALF;
            default:     sz = SZ_WORD;
         endcase
      end
      return sz;
   endfunction

endpackage

// File: rtl/load_align.sv
// load_align: combinational extraction and extension of a load result.
// Shared with the writeback stage.
// Ports:
//   word   in  DATA_WIDTH  full memory word
//   offset in  2           byte offset within the word (already aligned to size)
//   funct3 in  3           access type (LB/LH/LW/LBU/LHU; others treated as word)
//   data   out DATA_WIDTH  sign- or zero-extended result
module load_align
   import mem_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
   input  logic [DATA_WIDTH-1:0] word,
   input  logic [1:0]            offset,
   input  logic [2:0]            funct3,
   output logic [DATA_WIDTH-1:0] data
);

   logic [BYTE_WIDTH-1:0] byte_lane;
   logic [HALF_WIDTH-1:0] half_lane;

   assign byte_lane = word[{offset, 3'b000} +: BYTE_WIDTH];
   // Halfwords only ever sit at offset 0 or 2.
   assign half_lane = word[{offset[1], 4'b0000} +: HALF_WIDTH];

   always_comb begin
      data = word;
      case (funct3)
         F3_B:    data = {{(DATA_WIDTH-BYTE_WIDTH){byte_lane[BYTE_WIDTH-1]}}, byte_lane};
         F3_BU:   data = {{(DATA_WIDTH-BYTE_WIDTH){1'b0}}, byte_lane};
         F3_H:    data = {{(DATA_WIDTH-HALF_WIDTH){half_lane[HALF_WIDTH-1]}}, half_lane};
         F3_HU:   data = {{(DATA_WIDTH-HALF_WIDTH){1'b0}}, half_lane};
         default: data = word;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store sequencer in front of a word-wide
// data memory with combinational reads.
//   Loads  : IDLE -> LOAD  -> IDLE (loadValid pulses in the cycle back in IDLE)
//   SW     : IDLE -> WRITE -> IDLE
//   SB/SH  : IDLE -> MERGE -> WRITE -> IDLE (read-modify-write of the word)
// Handshake: a request is taken on a rising edge where the unit is IDLE
// (stall low) and exValid is high with exRead or exWrite; upstream holds the
// request unchanged while stall is high. Read and write together is a store.
// Build option MEM_MISALIGN_TRAP_EN: misaligned half/word accesses are taken,
// dropped without memory activity, and flagged by a one-cycle misalign pulse.
// Without it, low address bits below the access size are ignored.
// Ports:
//   clk, rstn                      clock, asynchronous active-low reset
//   exValid/exRead/exWrite         request qualifiers from EX/MEM
//   exFunct3/exAddr/exWriteData    access type, byte address, store data
//   exPc                           PC of the request
//   stall                          unit busy
//   memReadAddr/memWriteAddr       word-aligned captured address
//   memWriteEnable/memWriteData    one-cycle full-word write
//   memPc                          PC of the captured request
//   memReadData                    combinational read data
//   loadData/loadValid             extended load result, one-cycle pulse
//   misalign                       misaligned-access pulse
//   fsm_state                      current FSM state (observation only)
module mem_access_unit
   import mem_pkg::*;
#(
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  exValid,
   input  logic                  exRead,
   input  logic                  exWrite,
   input  logic [2:0]            exFunct3,
   input  logic [ADDR_WIDTH-1:0] exAddr,
   input  logic [DATA_WIDTH-1:0] exWriteData,
   input  logic [ADDR_WIDTH-1:0] exPc,
   output logic                  stall,
   output logic [ADDR_WIDTH-1:0] memReadAddr,
   output logic [ADDR_WIDTH-1:0] memWriteAddr,
   output logic                  memWriteEnable,
   output logic [DATA_WIDTH-1:0] memWriteData,
   output logic [ADDR_WIDTH-1:0] memPc,
   input  logic [DATA_WIDTH-1:0] memReadData,
   output logic [DATA_WIDTH-1:0] loadData,
   output logic                  loadValid,
   output logic                  misalign,
   output mem_state_t            fsm_state
);

   mem_state_t            state, state_next;
   access_size_t          size_in;
   logic                  accept;
   logic                  mis_in;
   logic [1:0]            off_in;

   logic [ADDR_WIDTH-1:0] addr_q;
   logic [ADDR_WIDTH-1:0] pc_q;
   logic [1:0]            off_q;
   logic [2:0]            f3_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [DATA_WIDTH-1:0] load_data_q;
   logic                  load_valid_q;

   logic [DATA_WIDTH-1:0] aligned_data;
   logic [DATA_WIDTH-1:0] lane_mask;
   logic [DATA_WIDTH-1:0] lane_data;
   logic [DATA_WIDTH-1:0] merged;

   // Request decode and next state.
   always_comb begin
      size_in = access_size(exFunct3, exWrite);
      mis_in  = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      mis_in  = ((size_in == SZ_HALF) && exAddr[0]) ||
                ((size_in == SZ_WORD) && (exAddr[1:0] != 2'b00));
`endif
      accept     = (state == ST_IDLE) && exValid && (exRead || exWrite);
      state_next = state;
      case (state)
         ST_IDLE: begin
            if (accept && !mis_in) begin
               if (!exWrite)                state_next = ST_LOAD;
               else if (size_in == SZ_WORD) state_next = ST_WRITE;
               else                         state_next = ST_MERGE;
            end
         end
         ST_LOAD:  state_next = ST_IDLE;
         ST_MERGE: state_next = ST_WRITE;
         ST_WRITE: state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   // Byte offset forced to the access size; a trapped misaligned access
   // never uses it.
   always_comb begin
      off_in = 2'b00;
      case (size_in)
         SZ_BYTE: off_in = exAddr[1:0];
         SZ_HALF: off_in = {exAddr[1], 1'b0};
         default: off_in = 2'b00;
      endcase
   end

   // Read-modify-write: replace the addressed byte/half lane of the word.
   always_comb begin
      if (f3_q == F3_H)
         lane_mask = DATA_WIDTH'(16'hFFFF) << {off_q, 3'b000};
      else
         lane_mask = DATA_WIDTH'(8'hFF) << {off_q, 3'b000};
      lane_data = wdata_q << {off_q, 3'b000};
      merged    = (memReadData & ~lane_mask) | (lane_data & lane_mask);
   end

   load_align #(.DATA_WIDTH(DATA_WIDTH)) u_load_align (
      .word   (memReadData),
      .offset (off_q),
      .funct3 (f3_q),
      .data   (aligned_data)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= ST_IDLE;
      else       state <= state_next;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         addr_q       <= '0;
         pc_q         <= '0;
         off_q        <= '0;
         f3_q         <= '0;
         wdata_q      <= '0;
         load_data_q  <= '0;
         load_valid_q <= 1'b0;
      end else begin
         load_valid_q <= (state == ST_LOAD);
         if (accept) begin
            addr_q  <= {exAddr[ADDR_WIDTH-1:2], 2'b00};
            pc_q    <= exPc;
            off_q   <= off_in;
            f3_q    <= exFunct3;
            wdata_q <= exWriteData;
         end
         if (state == ST_MERGE) wdata_q     <= merged;
         if (state == ST_LOAD)  load_data_q <= aligned_data;
      end
   end

`ifdef MEM_MISALIGN_TRAP_EN
   logic misalign_q;
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) misalign_q <= 1'b0;
      else       misalign_q <= accept && mis_in;
   end
   assign misalign = misalign_q;
`else
   assign misalign = 1'b0;
`endif

   assign stall          = (state != ST_IDLE);
   assign memWriteEnable = (state == ST_WRITE);
   assign memReadAddr    = addr_q;
   assign memWriteAddr   = addr_q;
   assign memWriteData   = wdata_q;
   assign memPc          = pc_q;
   assign loadData       = load_data_q;
   assign loadValid      = load_valid_q;
   assign fsm_state      = state;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed stimulus for mem_access_unit with a small
// word memory model. Expected load results, writes and misalign pulses are
// queued at acceptance together with the cycle they must appear in; a monitor
// on the falling edge pops and compares whenever the DUT presents one.
module tb_mem_access_unit;
   import mem_pkg::*;

   localparam int K_NONE  = 0;
   localparam int K_LOAD  = 1;
   localparam int K_WRITE = 2;
   localparam int K_MIS   = 3;

   // ---------------- clock / reset ----------------
   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [31:0] cyc = 32'd0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 32'd1;

   // ---------------- DUT ----------------
   logic        exValid = 1'b0, exRead = 1'b0, exWrite = 1'b0;
   logic [2:0]  exFunct3 = 3'b0;
   logic [31:0] exAddr = 32'd0, exWriteData = 32'd0, exPc = 32'd0;
   logic        stall, memWriteEnable, loadValid, misalign;
   logic [31:0] memReadAddr, memWriteAddr, memWriteData, memPc, memReadData, loadData;
   mem_state_t  fsm_state;

   mem_access_unit dut (
      .clk(clk), .rstn(rstn),
      .exValid(exValid), .exRead(exRead), .exWrite(exWrite),
      .exFunct3(exFunct3), .exAddr(exAddr), .exWriteData(exWriteData), .exPc(exPc),
      .stall(stall), .memReadAddr(memReadAddr), .memWriteAddr(memWriteAddr),
      .memWriteEnable(memWriteEnable), .memWriteData(memWriteData), .memPc(memPc),
      .memReadData(memReadData), .loadData(loadData), .loadValid(loadValid),
      .misalign(misalign), .fsm_state(fsm_state)
   );

   // ---------------- memory model ----------------
   logic [31:0] mem [0:63];
   assign memReadData = mem[memReadAddr[7:2]];
   always @(posedge clk) if (memWriteEnable) mem[memWriteAddr[7:2]] <= memWriteData;

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_fail   = 0;
   logic [31:0] exp_ld_data_q[$], exp_ld_cyc_q[$];
   logic [31:0] exp_wr_addr_q[$], exp_wr_data_q[$], exp_wr_pc_q[$], exp_wr_cyc_q[$];
   logic [31:0] exp_mis_cyc_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: event with nothing expected (cycle %0d)", name, cyc);
   endtask

   always @(negedge clk) begin
      if (loadValid) begin
         if (exp_ld_data_q.size() == 0) fail_now("load_unexpected");
         else begin
            check("load_data", loadData, exp_ld_data_q.pop_front());
            check("load_cycle", cyc, exp_ld_cyc_q.pop_front());
         end
      end
      if (memWriteEnable) begin
         if (exp_wr_addr_q.size() == 0) fail_now("write_unexpected");
         else begin
            check("write_addr", memWriteAddr, exp_wr_addr_q.pop_front());
            check("write_data", memWriteData, exp_wr_data_q.pop_front());
            check("write_pc", memPc, exp_wr_pc_q.pop_front());
            check("write_cycle", cyc, exp_wr_cyc_q.pop_front());
         end
      end
      if (misalign) begin
         if (exp_mis_cyc_q.size() == 0) fail_now("misalign_unexpected");
         else check("misalign_cycle", cyc, exp_mis_cyc_q.pop_front());
      end
   end

   // ---------------- driver tasks ----------------
   // Called on a falling edge; returns on the falling edge after acceptance.
   task automatic issue(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] pc, input int kind,
                        input logic [31:0] e_addr, input logic [31:0] e_data,
                        input int lat, output logic lv_at_acc);
      int n;
      exValid = 1'b1; exRead = rd; exWrite = wr; exFunct3 = f3;
      exAddr = addr; exWriteData = wdata; exPc = pc;
      n = 0;
      while (stall && n < 50) begin
         @(negedge clk);
         n++;
      end
      lv_at_acc = loadValid;
      if (stall) fail_now("accept_timeout");
      else begin
         case (kind)
            K_LOAD: begin
               exp_ld_data_q.push_back(e_data);
               exp_ld_cyc_q.push_back(cyc + 32'(lat));
            end
            K_WRITE: begin
               exp_wr_addr_q.push_back(e_addr);
               exp_wr_data_q.push_back(e_data);
               exp_wr_pc_q.push_back(pc);
               exp_wr_cyc_q.push_back(cyc + 32'(lat));
            end
            K_MIS: exp_mis_cyc_q.push_back(cyc + 32'(lat));
            default: ;
         endcase
      end
      @(negedge clk);
      exValid = 1'b0; exRead = 1'b0; exWrite = 1'b0;
   endtask

   task automatic wait_idle(output int n);
      n = 0;
      while (stall && n < 20) begin
         n++;
         @(negedge clk);
      end
   endtask

   task automatic do_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] exp);
      logic lv;
      int   n;
      issue(1'b1, 1'b0, f3, addr, 32'h0, 32'h200, K_LOAD, 32'h0, exp, 2, lv);
      wait_idle(n);
      check("load_stall_cycles", 32'(n), 32'd1);
   endtask

   task automatic do_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data,
                           input logic [31:0] pc, input logic [31:0] e_addr,
                           input logic [31:0] e_data, input int lat);
      logic lv;
      int   n;
      issue(1'b1, 1'b1, f3, addr, data, pc, K_WRITE, e_addr, e_data, lat, lv);
      wait_idle(n);
      check("store_stall_cycles", 32'(n), 32'(lat));
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // ---------------- directed sequence ----------------
   initial begin
      logic lv;
      int   n;
      for (int i = 0; i < 64; i++) mem[i] = 32'h0;
      mem[4] = 32'h8899AABB;   // word 0x10
      mem[5] = 32'h12345678;   // word 0x14

      #12;
      check("rst_stall", {31'b0, stall}, 32'd0);
      check("rst_we", {31'b0, memWriteEnable}, 32'd0);
      check("rst_load_valid", {31'b0, loadValid}, 32'd0);
      check("rst_misalign", {31'b0, misalign}, 32'd0);
      check("rst_load_data", loadData, 32'd0);
      check("rst_addr", memWriteAddr, 32'd0);
      check("rst_wdata", memWriteData, 32'd0);
      check("rst_pc", memPc, 32'd0);
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);

      // Loads: extraction and extension.
      do_load(F3_B,  32'h11, 32'hFFFFFFAA);
      do_load(F3_BU, 32'h11, 32'h000000AA);
      do_load(F3_H,  32'h12, 32'hFFFF8899);
      do_load(F3_HU, 32'h12, 32'h00008899);
      do_load(F3_W,  32'h10, 32'h8899AABB);
      do_load(F3_B,  32'h13, 32'hFFFFFF88);
      do_load(F3_BU, 32'h10, 32'h000000BB);
      do_load(F3_B,  32'h14, 32'h00000078);
      do_load(F3_H,  32'h16, 32'h00001234);
      do_load(3'b011, 32'h14, 32'h12345678);

      // exValid without read or write is no request.
      exValid = 1'b1; exAddr = 32'h10;
      repeat (3) begin
         @(negedge clk);
         check("noreq_stall", {31'b0, stall}, 32'd0);
      end
      exValid = 1'b0;

      // Stores.
      do_store(F3_W, 32'h10, 32'h11223344, 32'h100, 32'h10, 32'h11223344, 1);
      do_store(F3_B, 32'h12, 32'h1234565C, 32'h104, 32'h10, 32'h115C3344, 2);
      do_load(F3_W, 32'h10, 32'h115C3344);
      do_store(F3_W, 32'h20, 32'hDEADBEEF, 32'h40, 32'h20, 32'hDEADBEEF, 1);
      check("hold_addr", memWriteAddr, 32'h20);
      check("hold_read_addr", memReadAddr, 32'h20);
      check("hold_pc", memPc, 32'h40);
      do_store(F3_H, 32'h22, 32'h0000A5A5, 32'h108, 32'h20, 32'hA5A5BEEF, 2);

      // Back-to-back LW then SH with exValid held across.
      issue(1'b1, 1'b0, F3_W, 32'h20, 32'h0, 32'h10C, K_LOAD, 32'h0, 32'hA5A5BEEF, 2, lv);
      issue(1'b1, 1'b1, F3_H, 32'h20, 32'h00001357, 32'h110, K_WRITE, 32'h20, 32'hA5A51357, 2, lv);
      check("b2b_accept_on_load_valid", {31'b0, lv}, 32'd1);
      wait_idle(n);
      check("b2b_store_stall", 32'(n), 32'd2);

      // Misaligned halfword.
`ifdef MEM_MISALIGN_TRAP_EN
      issue(1'b1, 1'b1, F3_H, 32'h13, 32'h00007788, 32'h114, K_MIS, 32'h0, 32'h0, 1, lv);
      wait_idle(n);
      check("misalign_stall", 32'(n), 32'd0);
      @(negedge clk);
      check("misalign_mem_unchanged", mem[4], 32'h115C3344);
`else
      do_store(F3_H, 32'h13, 32'h00007788, 32'h114, 32'h10, 32'h77883344, 2);
`endif

      // Reset during MERGE aborts the store.
      issue(1'b1, 1'b1, F3_B, 32'h14, 32'h000000FF, 32'h118, K_NONE, 32'h0, 32'h0, 0, lv);
      check("merge_state", {30'b0, fsm_state}, {30'b0, ST_MERGE});
      rstn = 1'b0;
      #1;
      check("abort_stall", {31'b0, stall}, 32'd0);
      check("abort_we", {31'b0, memWriteEnable}, 32'd0);
      check("abort_wdata", memWriteData, 32'd0);
      check("abort_state", {30'b0, fsm_state}, {30'b0, ST_IDLE});
      @(negedge clk);
      rstn = 1'b1;
      repeat (4) @(negedge clk);
      check("abort_mem_unchanged", mem[5], 32'h12345678);

      repeat (3) @(negedge clk);
      check("pending_loads", 32'(exp_ld_data_q.size()), 32'd0);
      check("pending_writes", 32'(exp_wr_addr_q.size()), 32'd0);
      check("pending_misalign", 32'(exp_mis_cyc_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, byte address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, memory word width.
REQ-003 SHALL have port clk  in  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rstn  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port exValid  in  1  request from EX/MEM register.
REQ-006 SHALL have port exRead  in  1  load request.
REQ-007 SHALL have port exWrite  in  1  store request.
REQ-008 SHALL have port exFunct3  in  3  access type: LB/SB 000, LH/SH 001, LW/SW 010, LBU 100, LHU 101.
REQ-009 SHALL have port exAddr  in  ADDR_WIDTH  byte address.
REQ-010 SHALL have port exWriteData  in  DATA_WIDTH  store data, right-justified.
REQ-011 SHALL have port exPc  in  ADDR_WIDTH  PC of the request.
REQ-012 SHALL have port stall  out  1  busy; upstream holds its request while high.
REQ-013 SHALL have ports memReadAddr  out  ADDR_WIDTH and memWriteAddr  out  ADDR_WIDTH  word-aligned addresses to data memory.
REQ-014 SHALL have ports memWriteEnable  out  1 and memWriteData  out  DATA_WIDTH  full-word write to data memory.
REQ-015 SHALL have port memPc  out  ADDR_WIDTH  PC of the in-flight store, for the memory's trace output.
REQ-016 SHALL have port memReadData  in  DATA_WIDTH  combinational read data from data memory.
REQ-017 SHALL have ports loadData  out  DATA_WIDTH and loadValid  out  1  extended load result, one-cycle pulse.
REQ-018 SHALL have port misalign  out  1  misaligned-access pulse.

Function
REQ-019 SHALL implement FSM states IDLE, LOAD, MERGE, WRITE; stall SHALL equal (state != IDLE).
REQ-020 SHALL accept a request only in IDLE with exValid high, capturing funct3, address, data and PC.
REQ-021 SHALL treat exRead and exWrite both high as a store, and exValid with neither as no request.
REQ-022 Load: IDLE->LOAD; in LOAD drive memReadAddr, register the extracted/extended byte, half or word; in the next cycle pulse loadValid with loadData and return to IDLE, where a new request may be accepted in that same cycle.
REQ-023 SW: IDLE->WRITE; in WRITE assert memWriteEnable for exactly one cycle with memWriteData equal to the captured data.
REQ-024 SB/SH: IDLE->MERGE; in MERGE read the word, capture memReadData and merge in the byte/half at addr[1:0]; then WRITE writes the merged word.
REQ-025 memWriteAddr, memReadAddr and memPc SHALL hold the captured values from acceptance until the next acceptance.
REQ-026 LB/LH SHALL sign-extend and LBU/LHU SHALL zero-extend; funct3 codes not listed SHALL be treated as word.
REQ-027 Latency: load result 2 cycles after acceptance; SW write 1 cycle after acceptance; SB/SH write 2 cycles after acceptance.

Reset
REQ-028 rstn low SHALL immediately force state IDLE, and stall, memWriteEnable, loadValid and misalign to 0; loadData, memReadAddr, memWriteAddr, memWriteData and memPc SHALL reset to 0.
REQ-029 Reset during MERGE or WRITE SHALL abort the store with no partial write, and SHALL discard the captured word.

Configuration
REQ-030 With MEM_MISALIGN_TRAP_EN defined, a halfword with addr[0]=1 or a word with addr[1:0]!=0 SHALL be accepted, then drop to IDLE with no memory write and no loadValid, pulsing misalign one cycle after acceptance.
REQ-031 Without MEM_MISALIGN_TRAP_EN, address bits below the access size SHALL be ignored (access forced aligned), and misalign SHALL be tied 0.

Structure
REQ-032 The funct3 codes, the FSM state encoding and the width constants SHALL reside in shared package mem_pkg.
REQ-033 Byte/half extraction and extension SHALL be a combinational sub-module load_align, reused by the writeback stage.

Verification
REQ-034 Memory word 0x10 = 0x8899AABB; LB at 0x11 -> loadValid 2 cycles later with loadData 0xFFFFFFAA; LBU at 0x11 -> 0x000000AA.
REQ-035 SB 0x5C to 0x12 with word 0x10 = 0x11223344 -> memWriteEnable one cycle, memWriteAddr 0x10, memWriteData 0x115C3344, stall high 2 cycles.
REQ-036 SW 0xDEADBEEF to 0x20, PC 0x40 -> next cycle memWriteEnable=1, memWriteAddr 0x20, memPc 0x40, stall high 1 cycle.
REQ-037 Back-to-back LW then SH with exValid held -> second request accepted the cycle loadValid pulses, nothing lost or duplicated.
REQ-038 SH to 0x13: with MEM_MISALIGN_TRAP_EN -> misalign pulse, no write; without it -> write to halfword 0x12.
REQ-039 rstn low during MERGE -> memWriteEnable never asserted, stall 0 immediately, memory unchanged.
